// File: rtl/prep_scheduler.sv
// Sequences the shared angle/sin/cos/rotate datapath over the shape slots:
// dirty-mask tracking, round-robin selection, one request in flight at a time.
module prep_scheduler #(
  parameter int MAXSHP = 16,
  parameter int IDW    = 4,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MAXSHP-1:0] mark,
  input  logic              mark_all,
  input  logic              endframe,
  input  logic              stall,
  output logic              issue,
  output logic [IDW-1:0]    issue_id,
  output logic              wb_en,
  output logic [IDW-1:0]    wb_id,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [MAXSHP-1:0] dirty
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_WRITE, S_FIN
  } state_t;

  state_t            state_q;
  logic [MAXSHP-1:0] dirty_q, dirty_d;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    sel_q;
  logic [CW-1:0]     cnt_q;
  logic              overrun_q;

  // Candidate slot for each search offset: (ptr + 1 + gi) mod MAXSHP.
  logic [IDW-1:0] cand_id [MAXSHP];
  for (genvar gi = 0; gi < MAXSHP; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum = {1'b0, ptr_q} + (IDW+1)'(gi + 1);
    assign cand_id[gi] = (sum >= (IDW+1)'(MAXSHP)) ? IDW'(sum - (IDW+1)'(MAXSHP))
                                                   : sum[IDW-1:0];
  end

  logic           found;
  logic [IDW-1:0] found_id;

  // Walk from the farthest offset down so the nearest dirty slot wins.
  always_comb begin
    found    = 1'b0;
    found_id = '0;
    for (int i = MAXSHP - 1; i >= 0; i--) begin
      if (dirty_q[cand_id[i]]) begin
        found    = 1'b1;
        found_id = cand_id[i];
      end
    end
  end

  // A mark landing in the issue cycle keeps the slot dirty for a later pass.
  always_comb begin
    dirty_d = dirty_q | mark | {MAXSHP{mark_all}};
    if (state_q == S_ISSUE) dirty_d[sel_q] = mark[sel_q] | mark_all;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dirty_q   <= '1;
      ptr_q     <= IDW'(MAXSHP - 1);
      sel_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      dirty_q   <= dirty_d;
      overrun_q <= endframe && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (endframe) state_q <= (|dirty_q) ? S_SCAN : S_FIN;
        end
        S_SCAN: begin
          if (!found) begin
            state_q <= S_FIN;
          end else if (!stall) begin
            sel_q   <= found_id;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ptr_q   <= sel_q;
          cnt_q   <= CW'(LAT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_WRITE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_WRITE: state_q <= S_SCAN;
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign issue    = (state_q == S_ISSUE);
  assign wb_en    = (state_q == S_WRITE);
  assign done     = (state_q == S_FIN);
  assign busy     = (state_q != S_IDLE);
  assign issue_id = sel_q;
  assign wb_id    = sel_q;
  assign overrun  = overrun_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_prep_scheduler.sv
// Directed bench for prep_scheduler: sweep order, write-back latency, marks,
// stall, overrun and mid-flight reset.
module tb_prep_scheduler;
  localparam int MAXSHP = 16;
  localparam int IDW    = 4;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [MAXSHP-1:0] mark = '0;
  logic              mark_all = 1'b0;
  logic              endframe = 1'b0;
  logic              stall = 1'b0;
  logic              issue, wb_en, busy, done, overrun;
  logic [IDW-1:0]    issue_id, wb_id;
  logic [MAXSHP-1:0] dirty;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int iss_ids[$];
  int iss_ts[$];
  int wb_ids[$];
  int wb_ts[$];
  int done_cnt = 0;

  prep_scheduler #(.MAXSHP(MAXSHP), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .mark(mark), .mark_all(mark_all),
    .endframe(endframe), .stall(stall), .issue(issue), .issue_id(issue_id),
    .wb_en(wb_en), .wb_id(wb_id), .busy(busy), .done(done),
    .overrun(overrun), .dirty(dirty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (issue === 1'b1) begin
      iss_ids.push_back(int'(issue_id));
      iss_ts.push_back(cyc);
      $display("  cyc %0d issue id=%0d", cyc, issue_id);
    end
    if (wb_en === 1'b1) begin
      wb_ids.push_back(int'(wb_id));
      wb_ts.push_back(cyc);
      $display("  cyc %0d wb id=%0d", cyc, wb_id);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_endframe;
    endframe = 1'b1;
    tick();
    endframe = 1'b0;
  endtask

  task automatic pulse_mark(input logic [MAXSHP-1:0] m);
    mark = m;
    tick();
    mark = '0;
  endtask

  task automatic run_to_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0 || issue !== 1'b0 || wb_en !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: busy=%b issue=%b wb_en=%b done=%b overrun=%b, want all 0", busy, issue, wb_en, done, overrun);
    end
    total++; if (issue_id !== 4'd0 || wb_id !== 4'd0) begin
      bad++; $display("FAIL reset_ids: issue_id=%0d wb_id=%0d, want 0", issue_id, wb_id);
    end
    total++; if (dirty !== 16'hFFFF) begin
      bad++; $display("FAIL reset_dirty: got %h want ffff", dirty);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep;
    int b, bw, bd, n;
    b = iss_ids.size(); bw = wb_ids.size(); bd = done_cnt;
    pulse_endframe();
    run_to_idle(n);
    // 16 slots * (LAT+3) plus the empty SCAN and FIN
    total++; if (n !== 114) begin
      bad++; $display("FAIL sweep_len: got %0d busy cycles want 114", n);
    end
    total++; if (iss_ids.size() - b !== 16 || wb_ids.size() - bw !== 16) begin
      bad++; $display("FAIL sweep_count: issues=%0d wbs=%0d want 16/16", iss_ids.size() - b, wb_ids.size() - bw);
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (iss_ids[b+i] !== i || wb_ids[bw+i] !== i) begin
        bad++; $display("FAIL sweep_id[%0d]: issue=%0d wb=%0d want %0d", i, iss_ids[b+i], wb_ids[bw+i], i);
      end
      total++; if (wb_ts[bw+i] - iss_ts[b+i] !== 5) begin
        bad++; $display("FAIL sweep_lat[%0d]: got %0d want 5", i, wb_ts[bw+i] - iss_ts[b+i]);
      end
    end
    total++; if (done_cnt - bd !== 1) begin
      bad++; $display("FAIL sweep_done: got %0d pulses want 1", done_cnt - bd);
    end
    total++; if (dirty !== 16'h0000) begin
      bad++; $display("FAIL sweep_dirty: got %h want 0000", dirty);
    end
  endtask

  task automatic test_clean_pair;
    int b, bd, n;
    pulse_mark(16'h0208);
    total++; if (dirty !== 16'h0208) begin
      bad++; $display("FAIL pair_mark: got %h want 0208", dirty);
    end
    b = iss_ids.size(); bd = done_cnt;
    pulse_endframe();
    run_to_idle(n);
    // 16 busy cycles after the endframe cycle: 17 from endframe to IDLE
    total++; if (n !== 16) begin
      bad++; $display("FAIL pair_len: got %0d busy cycles want 16", n);
    end
    total++; if (iss_ids.size() - b !== 2 || iss_ids[b] !== 3 || iss_ids[b+1] !== 9) begin
      bad++; $display("FAIL pair_order: n=%0d first=%0d second=%0d want 2/3/9", iss_ids.size() - b, iss_ids[b], iss_ids[b+1]);
    end
    total++; if (done_cnt - bd !== 1) begin
      bad++; $display("FAIL pair_done: got %0d want 1", done_cnt - bd);
    end
  endtask

  task automatic test_mark_in_issue;
    int b, n;
    bit hit;
    pulse_mark(16'h10A0);
    b = iss_ids.size(); n = 0; hit = 1'b0;
    pulse_endframe();
    while (busy === 1'b1 && n < 1000) begin
      if (issue === 1'b1 && issue_id === 4'd5 && !hit) begin
        hit = 1'b1;
        mark = 16'h0020;
        tick();
        mark = '0;
        total++; if (dirty[5] !== 1'b1) begin
          bad++; $display("FAIL remark_dirty: got %b want 1", dirty[5]);
        end
      end else begin
        tick();
      end
      n++;
    end
    total++; if (iss_ids.size() - b !== 4 || iss_ids[b] !== 12 || iss_ids[b+1] !== 5 || iss_ids[b+2] !== 7 || iss_ids[b+3] !== 5) begin
      bad++; $display("FAIL remark_order: n=%0d ids=%0d,%0d,%0d,%0d want 12,5,7,5", iss_ids.size() - b, iss_ids[b], iss_ids[b+1], iss_ids[b+2], iss_ids[b+3]);
    end
    total++; if (dirty !== 16'h0000) begin
      bad++; $display("FAIL remark_final: got %h want 0000", dirty);
    end
  endtask

  task automatic test_stall;
    int b, n, held;
    pulse_mark(16'h0104);
    b = iss_ids.size();
    stall = 1'b1;
    pulse_endframe();
    held = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (issue === 1'b0 && busy === 1'b1) held++;
    end
    total++; if (held !== 10) begin
      bad++; $display("FAIL stall_hold: held %0d cycles want 10", held);
    end
    stall = 1'b0;
    tick();
    total++; if (issue !== 1'b1 || issue_id !== 4'd8) begin
      bad++; $display("FAIL stall_release: issue=%b id=%0d want 1/8", issue, issue_id);
    end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (wb_en !== 1'b1 || wb_id !== 4'd8) begin
      bad++; $display("FAIL stall_wait: wb_en=%b wb_id=%0d want 1/8", wb_en, wb_id);
    end
    stall = 1'b0;
    run_to_idle(n);
    total++; if (iss_ids.size() - b !== 2 || iss_ids[b+1] !== 2) begin
      bad++; $display("FAIL stall_next: n=%0d second=%0d want 2/2", iss_ids.size() - b, iss_ids[b+1]);
    end
  endtask

  task automatic test_overrun;
    int b, bd, n, quiet;
    pulse_mark(16'h0050);
    b = iss_ids.size(); bd = done_cnt;
    pulse_endframe();
    tick();
    tick();
    endframe = 1'b1;
    tick();
    endframe = 1'b0;
    total++; if (overrun !== 1'b1) begin
      bad++; $display("FAIL overrun_pulse: got %b want 1", overrun);
    end
    tick();
    total++; if (overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_clear: got %b want 0", overrun);
    end
    run_to_idle(n);
    total++; if (iss_ids.size() - b !== 2 || iss_ids[b] !== 4 || iss_ids[b+1] !== 6) begin
      bad++; $display("FAIL overrun_order: n=%0d ids=%0d,%0d want 4,6", iss_ids.size() - b, iss_ids[b], iss_ids[b+1]);
    end
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b0) quiet++;
    end
    total++; if (quiet !== 20 || done_cnt - bd !== 1) begin
      bad++; $display("FAIL overrun_norestart: idle=%0d done=%0d want 20/1", quiet, done_cnt - bd);
    end
  endtask

  task automatic test_reset_mid;
    int b, bw, n;
    mark_all = 1'b1;
    tick();
    mark_all = 1'b0;
    total++; if (dirty !== 16'hFFFF) begin
      bad++; $display("FAIL markall: got %h want ffff", dirty);
    end
    bw = wb_ids.size();
    pulse_endframe();
    tick();
    total++; if (issue !== 1'b1 || issue_id !== 4'd7) begin
      bad++; $display("FAIL midrst_issue: issue=%b id=%0d want 1/7", issue, issue_id);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || dirty !== 16'hFFFF) begin
      bad++; $display("FAIL midrst_state: busy=%b dirty=%h want 0/ffff", busy, dirty);
    end
    for (int i = 0; i < 10; i++) tick();
    total++; if (wb_ids.size() - bw !== 0) begin
      bad++; $display("FAIL midrst_wb: got %0d write-backs want 0", wb_ids.size() - bw);
    end
    b = iss_ids.size();
    pulse_endframe();
    run_to_idle(n);
    total++; if (iss_ids.size() - b !== 16 || iss_ids[b] !== 0) begin
      bad++; $display("FAIL midrst_restart: n=%0d first=%0d want 16/0", iss_ids.size() - b, iss_ids[b]);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_clean_pair();
    test_mark_in_issue();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prep_scheduler.md
Name: prep_scheduler

Overview:
- Sequences the single shared pre-processing datapath (angle → sin/cos → initial rotate) across the MAXSHP shape slots.
- Keeps a per-slot dirty mask and, once per frame, recomputes only the slots whose x/y/angle changed, in round-robin order.
- Has exactly one request in flight at a time, with a fixed-latency write-back strobe.
- Sits between the edit control FSM (source of `mark`, `stall`) and the `s_sin/s_cos/s_ix/s_iy` slot registers, which are written on `wb_en`.

Parameters:
- MAXSHP, 16, number of shape slots.
- IDW, 4, slot-id width; must satisfy 2^IDW >= MAXSHP.
- LAT, 4, shared datapath latency in cycles from operand capture to valid result; LAT >= 1.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  reset
- mark  in  MAXSHP  per-slot mark-dirty; bits are OR-ed into the dirty mask every cycle
- mark_all  in  1  sets every dirty bit
- endframe  in  1  one-cycle pulse; starts a sweep
- stall  in  1  holds new issues (e.g. a slot swap is in progress)
- issue  out  1  one-cycle strobe; datapath captures operands of slot `issue_id`
- issue_id  out  IDW  slot being issued
- wb_en  out  1  one-cycle strobe; write datapath results into slot `wb_id`
- wb_id  out  IDW  slot being written back
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a sweep finds no dirty slot
- overrun  out  1  one-cycle pulse when `endframe` arrives while busy
- dirty  out  MAXSHP  current dirty mask (debug and tube display)

Behaviour:
- Reset (rst is synchronous, active-high; clock is clk):
  - state = IDLE; dirty = all ones; ptr = MAXSHP-1; cnt = 0.
  - issue, wb_en, done, overrun, busy = 0; issue_id = wb_id = 0.
- States: IDLE, SCAN, ISSUE, WAIT, WRITE, FIN. All strobes are Moore-decoded from the registered state:
  - issue = (state == ISSUE)
  - wb_en = (state == WRITE)
  - done = (state == FIN)
- IDLE:
  - endframe && |dirty → SCAN.
  - endframe && dirty == 0 → FIN, so `done` still pulses once per frame.
- SCAN:
  - Round-robin priority search over dirty, starting at slot ptr+1 and wrapping modulo MAXSHP; registers sel.
  - No dirty bit set → FIN.
  - Found and !stall → ISSUE.
  - Found and stall → stay in SCAN and re-search every cycle.
- ISSUE (one cycle):
  - issue_id = sel; ptr <= sel; cnt <= LAT-1; → WAIT.
  - dirty[sel] <= mark[sel] | mark_all: a mark arriving in the issue cycle wins, so the slot is recomputed later in the same sweep.
- WAIT:
  - cnt decrements each cycle; at cnt == 0 → WRITE.
  - WAIT therefore lasts exactly LAT cycles.
  - stall has no effect on WAIT or WRITE: the in-flight request always completes.
- WRITE: wb_en = 1, wb_id = the issued id; → SCAN.
- FIN: done = 1; → IDLE.
- Timing:
  - ISSUE in cycle t → WRITE in cycle t+LAT+1.
  - Per-slot cost is LAT+3 cycles.
  - A full sweep of 16 slots with LAT = 4 takes 112 cycles plus the final SCAN and FIN.
- Marks:
  - mark and mark_all set bits in any state, including IDLE and mid-sweep.
  - A slot marked mid-sweep is picked up by the same sweep if the round-robin search reaches it before a SCAN comes up empty.
- Overrun: endframe in any state other than IDLE → overrun = 1 for the next cycle; the sweep continues unchanged and no restart is queued.
- ptr is 0..MAXSHP-1; increment wraps MAXSHP-1 → 0. Slot ids ≥ MAXSHP are never generated.
- Reset mid-operation: the next cycle is in reset state; a pending wb_en is never produced; dirty returns to all ones.

Test Plan:
- Reset, then endframe (LAT=4):
  - issue pulses for ids 0..15 in order, each wb_en with the same id exactly 5 cycles after its issue.
  - After slot 15: SCAN, FIN (done=1), then IDLE; dirty = 0.
- Clean state (ptr=15): set mark[9] and mark[3], then endframe → issues 3 then 9, then done; total 2·7+3 cycles from endframe to IDLE.
- Hold mark[5] high during the issue cycle of slot 5 → dirty[5] stays 1; slot 5 is issued a second time after the remaining dirty slots in the same sweep.
- stall=1 while SCAN has found a dirty slot:
  - issue stays 0 for 10 cycles.
  - Release stall → ISSUE the following cycle.
  - stall raised during WAIT does not delay WRITE.
- endframe pulse during WAIT → overrun=1 for one cycle; the sweep's id sequence is unchanged; no extra sweep follows.
- rst asserted in the 2nd WAIT cycle → busy=0 and wb_en never asserted; dirty = 0xFFFF; the next endframe restarts at slot 0.
